// File: rtl/bit_counter_sched.sv
// Round-robin scheduler that runs one shared bit-count datapath for two requesters.
// Latency: grant edge, then 1 LOAD + (msb+2, or 1 for zero) COUNT + 1 DONE cycle; done pulses after DONE.
// Backpressure: requests are levels held until done; a losing requester simply waits in IDLE.
module bit_counter_sched #(
    parameter int A_WIDTH = 8,
    parameter int R_WIDTH = 5,
    parameter int MAX_CNT = A_WIDTH + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0,
    input  logic [A_WIDTH-1:0] a0_in,
    input  logic               req1,
    input  logic [A_WIDTH-1:0] a1_in,
    input  logic               A_eq_0,
    input  logic               A0,
    input  logic [R_WIDTH-1:0] result,
    output logic [A_WIDTH-1:0] A,
    output logic               Load_A,
    output logic               Res_eq_0,
    output logic               R_Shift_A,
    output logic               Incr_Res,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               done0,
    output logic               done1,
    output logic [R_WIDTH-1:0] count_out,
    output logic               err
);

    localparam int WD_WIDTH = $clog2(MAX_CNT + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(MAX_CNT);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t              state;
    logic [A_WIDTH-1:0]  a_reg;
    logic                last_served;
    logic [WD_WIDTH-1:0] wd_cnt;
    logic                abort;
    logic                pick1;

    assign A         = a_reg;
    assign Load_A    = (state == LOAD);
    assign Res_eq_0  = (state == LOAD);
    assign R_Shift_A = (state == COUNT) && !A_eq_0;
    assign Incr_Res  = (state == COUNT) && !A_eq_0 && A0;

    // On a tie, requester 1 wins only when requester 0 was served last.
    assign pick1 = req1 && (!req0 || !last_served);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            last_served <= 1'b1;
            wd_cnt      <= '0;
            abort       <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            count_out   <= '0;
            err         <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        a_reg <= pick1 ? a1_in : a0_in;
                        grant <= pick1 ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    wd_cnt <= '0;
                    abort  <= 1'b0;
                    state  <= COUNT;
                end
                COUNT: begin
                    if (A_eq_0) begin
                        state <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        // A healthy datapath reaches zero within A_WIDTH shifts.
                        if (wd_cnt + 1'b1 == WD_LIMIT) begin
                            abort <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    count_out   <= result;
                    err         <= abort;
                    done0       <= grant[0];
                    done1       <= grant[1];
                    last_served <= grant[1];
                    grant       <= 2'b00;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_counter_sched.sv
// Bench for bit_counter_sched: stub datapath, job-level reference model, per-cycle compare.
module tb_bit_counter_sched;

    localparam int AW = 8;
    localparam int RW = 5;
    localparam int MC = AW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] a0_in = '0, a1_in = '0;
    logic          A_eq_0, A0;
    logic [RW-1:0] result;
    logic [AW-1:0] A;
    logic          Load_A, Res_eq_0, R_Shift_A, Incr_Res;
    logic [1:0]    grant;
    logic          busy, done0, done1, err;
    logic [RW-1:0] count_out;
    logic          stuck = 1'b0;

    int checks = 0;
    int failures = 0;

    bit_counter_sched #(.A_WIDTH(AW), .R_WIDTH(RW), .MAX_CNT(MC)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0_in(a0_in), .req1(req1), .a1_in(a1_in),
        .A_eq_0(A_eq_0), .A0(A0), .result(result),
        .A(A), .Load_A(Load_A), .Res_eq_0(Res_eq_0), .R_Shift_A(R_Shift_A), .Incr_Res(Incr_Res),
        .grant(grant), .busy(busy), .done0(done0), .done1(done1),
        .count_out(count_out), .err(err)
    );

    always #5 clk = ~clk;

    // Stub datapath; 'stuck' pins A_eq_0 low to provoke the watchdog.
    logic [AW-1:0] dp_a;
    logic [RW-1:0] dp_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_a <= '0;
            dp_r <= '0;
        end else begin
            if (Load_A) dp_a <= A;
            else if (R_Shift_A) dp_a <= dp_a >> 1;
            if (Res_eq_0) dp_r <= '0;
            else if (Incr_Res) dp_r <= dp_r + 1'b1;
        end
    end
    assign A_eq_0 = stuck ? 1'b0 : (dp_a == '0);
    assign A0     = dp_a[0];
    assign result = dp_r;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcount(input logic [AW-1:0] v);
        int n = 0;
        for (int i = 0; i < AW; i++) n += int'(v[i]);
        return n;
    endfunction

    // Number of COUNT-state cycles a job takes.
    function automatic int count_cycles(input logic [AW-1:0] v, input logic stk);
        int msb = -1;
        if (stk) return MC;
        for (int i = 0; i < AW; i++) if (v[i]) msb = i;
        return (msb < 0) ? 1 : msb + 2;
    endfunction

    // Job-level model: a job occupies m_len cycles (LOAD + COUNT + DONE) after its grant.
    int            m_left, m_len;
    logic          m_owner, m_last, m_stuck;
    logic [AW-1:0] m_op;
    logic [1:0]    e_grant;
    logic          e_busy, e_done0, e_done1, e_err;
    int            e_count;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_len = 0; m_owner = 1'b0; m_op = '0; m_last = 1'b1; m_stuck = 1'b0;
            e_grant = 2'b00; e_busy = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
            e_count = 0; e_err = 1'b0;
        end else begin
            e_done0 = 1'b0;
            e_done1 = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_count = popcount(m_op);
                    e_err   = m_stuck;
                    if (m_owner) e_done1 = 1'b1; else e_done0 = 1'b1;
                    m_last  = m_owner;
                    e_grant = 2'b00;
                    e_busy  = 1'b0;
                end
            end else if (req0 || req1) begin
                m_owner = (req0 && req1) ? ~m_last : req1;
                m_op    = m_owner ? a1_in : a0_in;
                m_stuck = stuck;
                m_len   = 2 + count_cycles(m_op, stuck);
                m_left  = m_len;
                e_grant = m_owner ? 2'b10 : 2'b01;
                e_busy  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        automatic bit load_ph = e_busy && (m_left == m_len);
        automatic bit cnt_ph  = e_busy && (m_left >= 2) && (m_left < m_len);
        chk("grant", int'(grant), int'(e_grant));
        chk("busy", int'(busy), int'(e_busy));
        chk("done0", int'(done0), int'(e_done0));
        chk("done1", int'(done1), int'(e_done1));
        chk("count_out", int'(count_out), e_count);
        chk("err", int'(err), int'(e_err));
        chk("Load_A", int'(Load_A), int'(load_ph));
        chk("Res_eq_0", int'(Res_eq_0), int'(load_ph));
        chk("R_Shift_A", int'(R_Shift_A), int'(cnt_ph && !A_eq_0));
        chk("Incr_Res", int'(Incr_Res), int'(cnt_ph && !A_eq_0 && A0));
        if (e_busy) chk("A", int'(A), int'(m_op));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output int who, output int cyc);
        who = -1;
        cyc = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            cyc++;
            if (done0 || done1) begin
                who = done1 ? 1 : 0;
                break;
            end
        end
        if (who < 0) begin
            failures++;
            $display("FAIL wait_done: no done pulse within %0d cycles", cyc);
        end
    endtask

    initial begin
        int who, cyc;
        repeat (3) step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count_out), 0);
        reset = 1'b0;
        step();

        req0 = 1'b1; a0_in = 8'hFF;
        wait_done(who, cyc);
        req0 = 1'b0;
        chk("ff_who", who, 0);
        chk("ff_lat", cyc, 12);
        chk("ff_count", int'(count_out), 8);
        chk("ff_err", int'(err), 0);
        step();

        req1 = 1'b1; a1_in = 8'h00;
        wait_done(who, cyc);
        chk("z_who", who, 1); chk("z_lat", cyc, 4); chk("z_count", int'(count_out), 0);
        a1_in = 8'h80;
        wait_done(who, cyc);
        chk("h80_lat", cyc, 12); chk("h80_count", int'(count_out), 1);
        a1_in = 8'h05;
        wait_done(who, cyc);
        req1 = 1'b0;
        chk("h05_lat", cyc, 7); chk("h05_count", int'(count_out), 2);
        step();

        reset = 1'b1;
        req0 = 1'b1; req1 = 1'b1; a0_in = 8'h0F; a1_in = 8'hF0;
        step();
        reset = 1'b0;
        wait_done(who, cyc);
        chk("tie1_who", who, 0); chk("tie1_count", int'(count_out), 4);
        wait_done(who, cyc);
        chk("tie2_who", who, 1); chk("tie2_count", int'(count_out), 4);
        wait_done(who, cyc);
        req0 = 1'b0; req1 = 1'b0;
        chk("tie3_who", who, 0);
        step();

        stuck = 1'b1;
        req0 = 1'b1; a0_in = 8'h03;
        wait_done(who, cyc);
        req0 = 1'b0;
        chk("wd_lat", cyc, 12); chk("wd_err", int'(err), 1); chk("wd_count", int'(count_out), 2);
        step();
        stuck = 1'b0;
        req0 = 1'b1; a0_in = 8'h01;
        wait_done(who, cyc);
        req0 = 1'b0;
        chk("wd_clear", int'(err), 0); chk("h01_count", int'(count_out), 1);
        step();

        req0 = 1'b1; a0_in = 8'hFF;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_load", int'(Load_A | R_Shift_A), 0);
        repeat (2) step();
        reset = 1'b0;
        wait_done(who, cyc);
        req0 = 1'b0;
        chk("post_rst_count", int'(count_out), 8);
        step();

        req0 = 1'b1; a0_in = 8'h07;
        repeat (2) step();
        req0 = 1'b0; a0_in = 8'hFF;
        wait_done(who, cyc);
        chk("drop_who", who, 0); chk("drop_count", int'(count_out), 3);
        step();

        for (int i = 0; i < 3000; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            a0_in = AW'($urandom);
            a1_in = AW'($urandom);
            if (m_left == 0 && $urandom_range(0, 19) == 0) stuck = ~stuck;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) step();
        stuck = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
